param_project_box: RTL and testbench

PARAM_PROJECT_BOX -- requirements
Module: param_project_box

---
 rtl/param_project_box.sv | 159 +++++++++++++++
 tb/tb_param_project_box.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_project_box.sv
`default_nettype none
// ============================================================================
// Module   : param_project_box
// Purpose  : Two-stage pipelined per-lane box projection (clip to [-B, +B])
//            of fixed-point vectors with a sideband tag and a runtime bound.
//            Optional clip counter enabled by macro PROJECT_BOX_CLIP_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module param_project_box #(
  parameter int TAG_WIDTH          = 32,
  parameter int LANES              = 4,
  parameter int DATA_WIDTH         = 8,
  parameter int IN_FRACTION_WIDTH  = 6,
  parameter int OUT_FRACTION_WIDTH = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [TAG_WIDTH-1:0]        tag_in,
  input  logic [DATA_WIDTH*LANES-1:0] data_in,
  input  logic                        cfg_load,
  input  logic [DATA_WIDTH-1:0]       cfg_bound,
  output logic                        cfg_ack,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [TAG_WIDTH-1:0]        tag_out,
  output logic [DATA_WIDTH*LANES-1:0] data_out,
  output logic                        busy
`ifdef PROJECT_BOX_CLIP_COUNT_EN
  ,
  output logic [$clog2(LANES+1)-1:0]  clip_count
`endif
);

  localparam int c_SHIFT = OUT_FRACTION_WIDTH - IN_FRACTION_WIDTH;
  localparam int c_EXT_W = DATA_WIDTH + c_SHIFT + 1;
  localparam int c_CNT_W = $clog2(LANES + 1);
  localparam logic [DATA_WIDTH-1:0] c_BOUND_RST =
    {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (OUT_FRACTION_WIDTH - 1);

  logic                        r_s1_valid;
  logic [TAG_WIDTH-1:0]        r_s1_tag;
  logic [DATA_WIDTH*LANES-1:0] r_s1_data;
  logic                        r_s2_valid;
  logic [TAG_WIDTH-1:0]        r_s2_tag;
  logic [DATA_WIDTH*LANES-1:0] r_s2_data;
  logic [DATA_WIDTH-1:0]       r_bound;
  logic                        r_cfg_ack;

  logic                        w_stall;
  logic                        w_busy;
  logic                        w_cfg_take;
  logic signed [c_EXT_W-1:0]   w_bound_ext;
  logic signed [c_EXT_W-1:0]   w_nbound_ext;
  logic [DATA_WIDTH*LANES-1:0] w_lane_res;

  assign w_stall    = r_s2_valid & ~ready_in;
  assign w_busy     = r_s1_valid | r_s2_valid;
  // Bound may only change with the pipeline drained, so no vector ever sees two bounds.
  assign w_cfg_take = cfg_load & ~w_busy & ~valid_in;

  assign w_bound_ext  = {{(c_EXT_W-DATA_WIDTH){r_bound[DATA_WIDTH-1]}}, r_bound};
  assign w_nbound_ext = -w_bound_ext;

`ifdef PROJECT_BOX_CLIP_COUNT_EN
  logic [LANES-1:0]   w_clip_flags;
  logic [c_CNT_W-1:0] w_clip_cnt;
  logic [c_CNT_W-1:0] r_clip_count;
`endif

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_WIDTH-1:0]     w_elem;
      logic signed [c_EXT_W-1:0] w_x;
      logic                      w_hi;
      logic                      w_lo;
      logic [DATA_WIDTH-1:0]     w_res;

      assign w_elem = r_s1_data[k*DATA_WIDTH +: DATA_WIDTH];
      assign w_x    = {{(c_EXT_W-DATA_WIDTH){w_elem[DATA_WIDTH-1]}}, w_elem} << c_SHIFT;
      assign w_hi   = (w_x >= w_bound_ext);
      assign w_lo   = (w_x <= w_nbound_ext);

      // Unclipped values satisfy |x| < B, so truncation to DATA_WIDTH is exact.
      always_comb begin
        w_res = w_x[DATA_WIDTH-1:0];
        if (w_hi) begin
          w_res = r_bound;
        end else if (w_lo) begin
          w_res = w_nbound_ext[DATA_WIDTH-1:0];
        end
      end

      assign w_lane_res[k*DATA_WIDTH +: DATA_WIDTH] = w_res;
`ifdef PROJECT_BOX_CLIP_COUNT_EN
      assign w_clip_flags[k] = w_hi | w_lo;
`endif
    end
  endgenerate

`ifdef PROJECT_BOX_CLIP_COUNT_EN
  always_comb begin
    w_clip_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_clip_cnt = w_clip_cnt + c_CNT_W'(w_clip_flags[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clip_count <= '0;
    end else if (!w_stall && r_s1_valid) begin
      r_clip_count <= w_clip_cnt;
    end
  end

  assign clip_count = r_clip_count;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_data  <= '0;
      r_bound    <= c_BOUND_RST;
      r_cfg_ack  <= 1'b0;
    end else begin
      r_cfg_ack <= w_cfg_take;
      if (w_cfg_take) begin
        r_bound <= cfg_bound;
      end
      if (!w_stall) begin
        r_s1_valid <= valid_in;
        if (valid_in) begin
          r_s1_tag  <= tag_in;
          r_s1_data <= data_in;
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_tag  <= r_s1_tag;
          r_s2_data <= w_lane_res;
        end
      end
    end
  end

  assign ready_out = ~w_stall;
  assign busy      = w_busy;
  assign cfg_ack   = r_cfg_ack;
  assign valid_out = r_s2_valid;
  assign tag_out   = r_s2_tag;
  assign data_out  = r_s2_data;

endmodule
`default_nettype wire

// File: tb/tb_param_project_box.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_project_box
// Purpose  : Directed self-checking bench for param_project_box (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_project_box;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] tag_in;
  logic [31:0] data_in;
  logic        cfg_load;
  logic [7:0]  cfg_bound;
  logic        cfg_ack;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] tag_out;
  logic [31:0] data_out;
  logic        busy;
`ifdef PROJECT_BOX_CLIP_COUNT_EN
  logic [2:0]  clip_count;
`endif

  int tests = 0;
  int fails = 0;

  param_project_box dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tag_in    (tag_in),
    .data_in   (data_in),
    .cfg_load  (cfg_load),
    .cfg_bound (cfg_bound),
    .cfg_ack   (cfg_ack),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .tag_out   (tag_out),
    .data_out  (data_out),
    .busy      (busy)
`ifdef PROJECT_BOX_CLIP_COUNT_EN
    ,
    .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_cc(input string name, input int exp);
`ifdef PROJECT_BOX_CLIP_COUNT_EN
    check(name, 64'(clip_count), 64'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one vector with an idle pipeline and check it two cycles later.
  task automatic one_vector(input string name, input logic [31:0] tag, input logic [31:0] din,
                            input logic [31:0] dexp, input int cexp);
    tag_in   = tag;
    data_in  = din;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check({name, "_busy_s1"}, 64'(busy), 64'd1);
    check({name, "_vout_s1"}, 64'(valid_out), 64'd0);
    tick();
    check({name, "_vout"}, 64'(valid_out), 64'd1);
    check({name, "_data"}, 64'(data_out), 64'(dexp));
    check({name, "_tag"}, 64'(tag_out), 64'(tag));
    check_cc({name, "_clipcnt"}, cexp);
    tick();
    check({name, "_drained"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    logic [7:0] b;

    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1; cfg_load = 1'b0;
    cfg_bound = 8'h00; tag_in = '0; data_in = '0;
    repeat (2) tick();
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_ack", 64'(cfg_ack), 64'd0);
    check("rst_tag_out", 64'(tag_out), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    reset = 1'b0;
    check("rst_ready_out", 64'(ready_out), 64'd1);

    // Basic clip with reset bound 0x40
    one_vector("basic", 32'hA5A5_0001, 32'hF010C040, 32'hE020C040, 2);
    // Exact +-B after alignment counts as clipped
    one_vector("edge", 32'h0000_00E0, 32'hE11FE020, 32'hC23EC040, 2);

    // Bound load while idle
    cfg_bound = 8'h30; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("cfg_ack_pulse", 64'(cfg_ack), 64'd1);
    tick();
    check("cfg_ack_single", 64'(cfg_ack), 64'd0);
    one_vector("b30", 32'h0000_0030, 32'h0008E81C, 32'h0010D030, 2);

    // Load attempted while busy is ignored; retry once idle succeeds
    tag_in = 32'h0000_0B0B; data_in = 32'h0008E81C; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; cfg_load = 1'b1; cfg_bound = 8'h7F;
    tick();
    check("busy_cfg_noack1", 64'(cfg_ack), 64'd0);
    check("busy_cfg_vout", 64'(valid_out), 64'd1);
    check("busy_cfg_oldB", 64'(data_out), 64'h0010D030);
    tick();
    check("busy_cfg_noack2", 64'(cfg_ack), 64'd0);
    check("busy_cfg_idle", 64'(busy), 64'd0);
    tick();
    check("retry_cfg_ack", 64'(cfg_ack), 64'd1);
    cfg_load = 1'b0;
    tick();
    one_vector("b7f", 32'h0000_007F, 32'h0008E81C, 32'h0010D038, 0);

    // Stream 8 vectors, downstream stalls for cycles 3..5
    sent = 0; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 60) begin
      ready_in = !(cyc >= 3 && cyc <= 5);
      valid_in = (sent < 8);
      b        = 8'(sent + 1);
      tag_in   = 32'(sent + 1);
      data_in  = {b, b, b, b};
      #1;
      if (cyc >= 3 && cyc <= 5) check("stall_ready_out", 64'(ready_out), 64'd0);
      if (valid_out && ready_in) begin
        b = 8'(2 * (recv + 1));
        check("stream_tag", 64'(tag_out), 64'(recv + 1));
        check("stream_data", 64'(data_out), 64'({b, b, b, b}));
        recv++;
      end
      if (valid_in && ready_out) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_in = 1'b0; ready_in = 1'b1;
    check("stream_recv_count", 64'(recv), 64'd8);
    check("stream_sent_count", 64'(sent), 64'd8);
    tick();
    check("stream_drained", 64'(busy), 64'd0);

    // Reset with two vectors in flight
    tag_in = 32'h11; data_in = 32'h00000030; valid_in = 1'b1;
    tick();
    tag_in = 32'h22;
    tick();
    valid_in = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_data_out", 64'(data_out), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("postrst_ready_out", 64'(ready_out), 64'd1);
    one_vector("postrst_B40", 32'h0000_0040, 32'h00000030, 32'h00000040, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
